rover_drive_ctrl: RTL and testbench

- Sequences the rover's dual H-bridge (IN1..IN4 direction pins, ENA/ENB enables) from the 3-bit inductive line sensor and the proximity obstacle flag.
- Debounces the sensor code, runs a line-following / obstacle-avoidance FSM, and drives both enables with a duty-cycle PWM.
- Sits between the sensor inputs and the Motor pins at top level and replaces direct motor wiring.

---
 rtl/rover_drive_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_rover_drive_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rover_drive_ctrl.sv
`default_nettype none
// ============================================================================
// Module : rover_drive_ctrl
// Brief  : Dual H-bridge sequencer: debounced line following, obstacle back-off
//          and PWM enables with dead time. Optional macro: ROVER_SOFT_START_EN.
// Rev    : 1.0
// ============================================================================
module rover_drive_ctrl #(
    parameter int PWM_BITS      = 8,
    parameter int DUTY_FWD      = 200,
    parameter int DUTY_TURN     = 150,
    parameter int DEBOUNCE      = 16,
    parameter int BRAKE_CYCLES  = 1000,
    parameter int REV_CYCLES    = 5000,
    parameter int SEARCH_CYCLES = 20000,
    parameter int DEAD_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [2:0] induct,
    input  logic       proxim,
    output logic [3:0] motor_in,
    output logic [1:0] motor_en,
    output logic [2:0] state,
    output logic       fault
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FWD    = 3'd1,
        S_TURN_L = 3'd2,
        S_TURN_R = 3'd3,
        S_SEARCH = 3'd4,
        S_BRAKE  = 3'd5,
        S_REV    = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    localparam int c_dwell_big = (REV_CYCLES > BRAKE_CYCLES) ? REV_CYCLES : BRAKE_CYCLES;
    localparam int c_dwell_max = (SEARCH_CYCLES > c_dwell_big) ? SEARCH_CYCLES : c_dwell_big;
    localparam int c_dwell_w   = $clog2(c_dwell_max + 1);
    localparam int c_db_w      = $clog2(DEBOUNCE + 1);
    localparam int c_dead_w    = $clog2(DEAD_CYCLES + 1);

    localparam logic [c_dwell_w-1:0] c_brake_last  = c_dwell_w'(BRAKE_CYCLES - 1);
    localparam logic [c_dwell_w-1:0] c_rev_last    = c_dwell_w'(REV_CYCLES - 1);
    localparam logic [c_dwell_w-1:0] c_search_last = c_dwell_w'(SEARCH_CYCLES - 1);
    localparam logic [c_db_w-1:0]    c_db_full     = c_db_w'(DEBOUNCE);
    localparam logic [c_db_w-1:0]    c_db_last     = c_db_w'(DEBOUNCE - 1);
    localparam logic [c_dead_w-1:0]  c_dead_load   = c_dead_w'(DEAD_CYCLES - 1);
    localparam logic [PWM_BITS-1:0]  c_duty_fwd    = PWM_BITS'(DUTY_FWD);
    localparam logic [PWM_BITS-1:0]  c_duty_turn   = PWM_BITS'(DUTY_TURN);

    state_t                r_state, w_next;
    logic [2:0]            r_ind_s1, r_ind_s2, r_db_cand, r_code;
    logic [c_db_w-1:0]     r_db_cnt;
    logic                  r_prox_s1, r_prox_s2;
    logic                  r_last_right;
    logic [c_dwell_w-1:0]  r_dwell;
    logic [c_dead_w-1:0]   r_dead;
    logic [PWM_BITS-1:0]   r_pwm, w_pwm_next, w_target, w_duty;
    logic [3:0]            w_dir;

    function automatic state_t line_state(input logic [2:0] code);
        state_t s;
        case (code)
            3'b010, 3'b111, 3'b101: s = S_FWD;
            3'b100, 3'b110:         s = S_TURN_L;
            3'b001, 3'b011:         s = S_TURN_R;
            default:                s = S_SEARCH;
        endcase
        return s;
    endfunction

    // The candidate count is the number of consecutive identical synchronised samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ind_s1  <= 3'b000;
            r_ind_s2  <= 3'b000;
            r_prox_s1 <= 1'b0;
            r_prox_s2 <= 1'b0;
            r_db_cand <= 3'b000;
            r_db_cnt  <= '0;
            r_code    <= 3'b000;
        end else begin
            r_ind_s1  <= induct;
            r_ind_s2  <= r_ind_s1;
            r_prox_s1 <= proxim;
            r_prox_s2 <= r_prox_s1;
            if (r_ind_s2 != r_db_cand) begin
                r_db_cand <= r_ind_s2;
                r_db_cnt  <= c_db_w'(1);
            end else if (r_db_cnt != c_db_full) begin
                r_db_cnt <= r_db_cnt + 1'b1;
                if (r_db_cnt == c_db_last) begin
                    r_code <= r_db_cand;
                end
            end
        end
    end

    always_comb begin
        w_next = r_state;
        if (!run) begin
            w_next = S_IDLE;
        end else if (r_state == S_FAULT) begin
            w_next = S_FAULT;
        end else if (r_prox_s2 && (r_state != S_BRAKE) && (r_state != S_REV)) begin
            w_next = S_BRAKE;
        end else begin
            case (r_state)
                S_BRAKE: if (r_dwell == c_brake_last) w_next = S_REV;
                S_REV:   if (r_dwell == c_rev_last)
                             w_next = r_prox_s2 ? S_BRAKE : line_state(r_code);
                S_SEARCH: begin
                    if (r_code != 3'b000)             w_next = line_state(r_code);
                    else if (r_dwell == c_search_last) w_next = S_FAULT;
                end
                default: w_next = line_state(r_code);
            endcase
        end
    end

    always_comb begin
        w_dir    = 4'b0000;
        w_target = '0;
        case (w_next)
            S_FWD:    begin w_dir = 4'b0101; w_target = c_duty_fwd;  end
            S_REV:    begin w_dir = 4'b1010; w_target = c_duty_fwd;  end
            S_TURN_L: begin w_dir = 4'b0110; w_target = c_duty_turn; end
            S_TURN_R: begin w_dir = 4'b1001; w_target = c_duty_turn; end
            S_SEARCH: begin w_dir = r_last_right ? 4'b1001 : 4'b0110; w_target = c_duty_turn; end
            default:  begin w_dir = 4'b0000; w_target = '0;          end
        endcase
    end

    assign w_pwm_next = run ? (r_pwm + 1'b1) : '0;

`ifdef ROVER_SOFT_START_EN
    logic [PWM_BITS-1:0] r_ramp, r_ramp_div, w_ramp_next, w_ramp_div_next;

    // Ramp restarts on every state change; only FORWARD/REVERSE are limited by it.
    always_comb begin
        w_ramp_next     = '0;
        w_ramp_div_next = '0;
        if (run && (w_next == r_state)) begin
            w_ramp_div_next = r_ramp_div + 1'b1;
            w_ramp_next     = ((r_ramp_div == '1) && (r_ramp != '1)) ? (r_ramp + 1'b1) : r_ramp;
        end
        w_duty = w_target;
        if (((w_next == S_FWD) || (w_next == S_REV)) && (w_ramp_next < w_target)) begin
            w_duty = w_ramp_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ramp     <= '0;
            r_ramp_div <= '0;
        end else begin
            r_ramp     <= w_ramp_next;
            r_ramp_div <= w_ramp_div_next;
        end
    end
`else
    always_comb begin
        w_duty = w_target;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            motor_in     <= 4'b0000;
            motor_en     <= 2'b00;
            fault        <= 1'b0;
            r_dwell      <= '0;
            r_dead       <= '0;
            r_pwm        <= '0;
            r_last_right <= 1'b0;
        end else begin
            r_state  <= w_next;
            fault    <= (w_next == S_FAULT);
            motor_in <= w_dir;
            r_pwm    <= w_pwm_next;
            if (w_next == S_TURN_L)      r_last_right <= 1'b0;
            else if (w_next == S_TURN_R) r_last_right <= 1'b1;

            if (!run || (w_next != r_state)) begin
                r_dwell <= '0;
            end else if ((r_state == S_BRAKE) || (r_state == S_REV) || (r_state == S_SEARCH)) begin
                r_dwell <= r_dwell + 1'b1;
            end

            // Enables are held off for the whole dead window, starting with the change cycle.
            if (!run) begin
                r_dead   <= '0;
                motor_en <= 2'b00;
            end else if (w_dir != motor_in) begin
                r_dead   <= c_dead_load;
                motor_en <= 2'b00;
            end else if (r_dead != '0) begin
                r_dead   <= r_dead - 1'b1;
                motor_en <= 2'b00;
            end else begin
                motor_en <= {2{w_pwm_next < w_duty}};
            end
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_rover_drive_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_rover_drive_ctrl
// Brief  : Scoreboard bench: per-cycle expected outputs from a behavioural model.
// Rev    : 1.0
// ============================================================================
module tb_rover_drive_ctrl;
    localparam int PWM_BITS      = 4;
    localparam int DUTY_FWD      = 12;
    localparam int DUTY_TURN     = 8;
    localparam int DEBOUNCE      = 4;
    localparam int BRAKE_CYCLES  = 3;
    localparam int REV_CYCLES    = 8;
    localparam int SEARCH_CYCLES = 20;
    localparam int DEAD_CYCLES   = 2;

    localparam int c_idle = 0, c_fwd = 1, c_tl = 2, c_tr = 3;
    localparam int c_search = 4, c_brake = 5, c_rev = 6, c_fault = 7;

    logic       clk = 1'b0;
    logic       rst, run, proxim;
    logic [2:0] induct;
    logic [3:0] motor_in;
    logic [1:0] motor_en;
    logic [2:0] state;
    logic       fault;

    rover_drive_ctrl #(
        .PWM_BITS(PWM_BITS), .DUTY_FWD(DUTY_FWD), .DUTY_TURN(DUTY_TURN),
        .DEBOUNCE(DEBOUNCE), .BRAKE_CYCLES(BRAKE_CYCLES), .REV_CYCLES(REV_CYCLES),
        .SEARCH_CYCLES(SEARCH_CYCLES), .DEAD_CYCLES(DEAD_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .induct(induct), .proxim(proxim),
        .motor_in(motor_in), .motor_en(motor_en), .state(state), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] mi;
        logic [1:0] en;
        logic [2:0] st;
        logic       flt;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle_no = 0;

    // Behavioural model state
    logic [2:0] m_ind1, m_ind2, m_code;
    logic       m_prox1, m_prox2, m_right;
    logic [2:0] m_hist[$];
    logic [3:0] m_mi;
    int         m_state, m_tis, m_pwm, m_since;

    function automatic int line_target(input logic [2:0] code);
        if (code == 3'b010 || code == 3'b111 || code == 3'b101) return c_fwd;
        if (code == 3'b100 || code == 3'b110) return c_tl;
        if (code == 3'b001 || code == 3'b011) return c_tr;
        return c_search;
    endfunction

    function automatic logic [3:0] pattern(input int st, input logic right);
        case (st)
            c_fwd:    return 4'b0101;
            c_rev:    return 4'b1010;
            c_tl:     return 4'b0110;
            c_tr:     return 4'b1001;
            c_search: return right ? 4'b1001 : 4'b0110;
            default:  return 4'b0000;
        endcase
    endfunction

    function automatic int duty_of(input int st);
        if (st == c_fwd || st == c_rev) return DUTY_FWD;
        if (st == c_tl || st == c_tr || st == c_search) return DUTY_TURN;
        return 0;
    endfunction

    task automatic model_step(input logic r, input logic rn, input logic [2:0] ind,
                              input logic px, output exp_t e);
        int         nxt;
        logic [3:0] d;
        bit         same;
        if (r) begin
            m_ind1 = 3'b000; m_ind2 = 3'b000; m_prox1 = 1'b0; m_prox2 = 1'b0;
            m_hist.delete();
            m_code = 3'b000; m_state = c_idle; m_tis = 0; m_pwm = 0;
            m_since = 1000; m_right = 1'b0; m_mi = 4'b0000;
            e.mi = 4'b0000; e.en = 2'b00; e.st = 3'd0; e.flt = 1'b0;
            return;
        end
        // Transition rules, in priority order, using the pre-edge code and obstacle flag
        if (!rn)                                            nxt = c_idle;
        else if (m_state == c_fault)                        nxt = c_fault;
        else if (m_prox2 && m_state != c_brake && m_state != c_rev) nxt = c_brake;
        else if (m_state == c_brake)                        nxt = (m_tis >= BRAKE_CYCLES) ? c_rev : c_brake;
        else if (m_state == c_rev)
            nxt = (m_tis >= REV_CYCLES) ? (m_prox2 ? c_brake : line_target(m_code)) : c_rev;
        else if (m_state == c_search && m_code == 3'b000)
            nxt = (m_tis >= SEARCH_CYCLES) ? c_fault : c_search;
        else                                                nxt = line_target(m_code);

        if (!rn || nxt != m_state) m_tis = 1;
        else                       m_tis++;

        d = pattern(nxt, m_right);
        if (nxt == c_tl) m_right = 1'b0;
        if (nxt == c_tr) m_right = 1'b1;

        // Debounce: accept when the last DEBOUNCE synchronised samples agree
        m_hist.push_back(m_ind2);
        if (m_hist.size() > DEBOUNCE) void'(m_hist.pop_front());
        if (m_hist.size() == DEBOUNCE) begin
            same = 1'b1;
            for (int i = 1; i < m_hist.size(); i++)
                if (m_hist[i] != m_hist[0]) same = 1'b0;
            if (same) m_code = m_hist[0];
        end
        m_ind2 = m_ind1; m_ind1 = ind;
        m_prox2 = m_prox1; m_prox1 = px;

        m_pwm = rn ? ((m_pwm + 1) % (1 << PWM_BITS)) : 0;
        if (!rn)            m_since = 1000;
        else if (d != m_mi) m_since = 0;
        else if (m_since < 1000) m_since++;
        m_mi    = d;
        m_state = nxt;

        e.mi  = d;
        e.en  = (rn && m_since >= DEAD_CYCLES && m_pwm < duty_of(nxt)) ? 2'b11 : 2'b00;
        e.st  = 3'(nxt);
        e.flt = (nxt == c_fault);
    endtask

    task automatic cyc(input logic r, input logic rn, input logic [2:0] ind, input logic px);
        exp_t e;
        @(negedge clk);
        rst = r; run = rn; induct = ind; proxim = px;
        model_step(r, rn, ind, px, e);
        exp_q.push_back(e);
    endtask

    task automatic hold(input int n, input logic [2:0] ind, input logic px);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, ind, px);
    endtask

    // Monitor: one comparison per clock against the oldest queued expectation
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cycle_no++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({motor_in, motor_en, state, fault} !== e) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d got mi=%b en=%b st=%0d flt=%b want mi=%b en=%b st=%0d flt=%b",
                             cycle_no, motor_in, motor_en, state, fault, e.mi, e.en, e.st, e.flt);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [2:0] v;
        int         len;
        logic       px, rn, r;
        rst = 1'b1; run = 1'b1; induct = 3'b010; proxim = 1'b0;

        // Reset, then settle into FORWARD
        cyc(1'b1, 1'b1, 3'b010, 1'b0);
        cyc(1'b1, 1'b1, 3'b010, 1'b0);
        hold(40, 3'b010, 1'b0);

        // Toggling faster than the debounce window must not disturb FORWARD
        for (int k = 0; k < 10; k++) hold(3, (k % 2 == 0) ? 3'b100 : 3'b010, 1'b0);
        hold(30, 3'b100, 1'b0);

        // Single-cycle obstacle pulse, then a held obstacle
        hold(20, 3'b010, 1'b0);
        hold(1, 3'b010, 1'b1);
        hold(30, 3'b010, 1'b0);
        hold(40, 3'b010, 1'b1);
        hold(30, 3'b010, 1'b0);

        // Line lost after a right turn: SEARCH pivots right, then FAULT
        hold(20, 3'b001, 1'b0);
        hold(40, 3'b000, 1'b0);
        hold(5, 3'b010, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 3'b010, 1'b0);

        // Reset while reversing
        hold(30, 3'b010, 1'b0);
        hold(1, 3'b010, 1'b1);
        hold(9, 3'b010, 1'b0);
        cyc(1'b1, 1'b1, 3'b010, 1'b0);
        hold(30, 3'b010, 1'b0);

        // Randomised bursts of held sensor codes with occasional obstacles, run drops and resets
        for (int k = 0; k < 80; k++) begin
            v   = 3'($urandom_range(0, 7));
            len = $urandom_range(1, 14);
            for (int j = 0; j < len; j++) begin
                px = ($urandom_range(0, 29) == 0);
                rn = ($urandom_range(0, 59) != 0);
                r  = ($urandom_range(0, 199) == 0);
                cyc(r, rn, v, px);
            end
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
